// File: rtl/tag_phase_seq_if.sv
// tag_phase_seq_if: AXI-Stream phase output bundle (tdata/tvalid/tready/tlast) with master/slave views
interface tag_phase_seq_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int NCH         = 2
);
    logic [NCH*PHASE_WIDTH-1:0] tdata;
    logic                       tvalid;
    logic                       tready;
    logic                       tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/tag_phase_seq.sv
// tag_phase_seq: symbol/location phase sequencer with per-channel offsets; TAG_PHASE_SEQ_DITHER_EN adds LFSR output dither
module tag_phase_seq #(
    parameter int PHASE_WIDTH = 24,
    parameter int CNT_WIDTH   = 24,
    parameter int NSYMB_WIDTH = 16,
    parameter int NLOC_WIDTH  = 3,
    parameter int NCH         = 2,
    parameter int DITHER_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       srst,
    input  logic                       start,
    input  logic                       cfg_oneshot,
    input  logic [CNT_WIDTH-1:0]       cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0]     cfg_nsymb,
    input  logic [NLOC_WIDTH-1:0]      cfg_nloc,
    input  logic [PHASE_WIDTH-1:0]     cfg_start_ph,
    input  logic [PHASE_WIDTH-1:0]     cfg_start_ph_inc,
    input  logic [PHASE_WIDTH-1:0]     cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0]     cfg_nph_shift,
    input  logic [NCH*PHASE_WIDTH-1:0] cfg_ch_offset,
    tag_phase_seq_if.master            m_phase,
    output logic                       busy,
    output logic                       sync_ready,
    output logic                       cfg_err,
    output logic [NSYMB_WIDTH-1:0]     symb_n,
    output logic [NLOC_WIDTH-1:0]      loc_n
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    typedef struct packed {
        logic [1:0]                 state;
        logic                       oneshot;
        logic [CNT_WIDTH-1:0]       nsig;
        logic [NSYMB_WIDTH-1:0]     nsymb;
        logic [NLOC_WIDTH-1:0]      nloc;
        logic [PHASE_WIDTH-1:0]     start_ph;
        logic [PHASE_WIDTH-1:0]     start_ph_inc;
        logic [PHASE_WIDTH-1:0]     dph_inc;
        logic [PHASE_WIDTH-1:0]     nph_shift;
        logic [NCH*PHASE_WIDTH-1:0] ch_offset;
        logic [PHASE_WIDTH-1:0]     phase;
        logic [PHASE_WIDTH-1:0]     inc;
        logic [PHASE_WIDTH-1:0]     sph;
        logic [CNT_WIDTH-1:0]       ncount;
        logic [NSYMB_WIDTH-1:0]     symb;
        logic [NLOC_WIDTH-1:0]      loc;
        logic [NCH*PHASE_WIDTH-1:0] tdata;
        logic                       tvalid;
        logic                       tlast;
        logic                       sync_ready;
        logic                       cfg_err;
    } regs_t;
    regs_t q, d;
    logic cfg_ok, go, hs, eos, eol, eop;
    logic [PHASE_WIDTH-1:0] dith;
    assign cfg_ok = |cfg_nsig && |cfg_nsymb && |cfg_nloc;
    assign go     = q.state == IDLE && start && cfg_ok;
    assign hs     = q.tvalid && m_phase.tready;
    assign eos    = q.ncount == q.nsig;
    assign eol    = eos && q.symb == q.nsymb;
    assign eop    = eol && q.loc == q.nloc - 1'b1;
`ifdef TAG_PHASE_SEQ_DITHER_EN
    logic [15:0] lfsr, lfsr_d;
    assign lfsr_d = hs ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
    assign dith   = PHASE_WIDTH'(lfsr_d[DITHER_BITS-1:0]);
    // Dither generator steps once per accepted sample
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) lfsr <= 16'hACE1;
        else lfsr <= srst ? 16'hACE1 : lfsr_d;
`else
    logic [DITHER_BITS-1:0] dbits;
    assign dbits = '0;
    assign dith  = PHASE_WIDTH'(dbits);
`endif
    // Next state: latch config on accepted start, step sample/symbol/location on each handshake
    always_comb begin
        d            = q;
        d.state      = q.state == IDLE ? (go ? RUN : IDLE)
                     : q.state == RUN  ? (hs && eop && q.oneshot ? DONE : RUN)
                     : IDLE;
        d.tvalid     = d.state == RUN;
        d.sync_ready = hs && eop;
        d.cfg_err    = q.state == IDLE && start && !cfg_ok;
        if (go) begin
            d.oneshot      = cfg_oneshot;
            d.nsig         = cfg_nsig;
            d.nsymb        = cfg_nsymb;
            d.nloc         = cfg_nloc;
            d.start_ph     = cfg_start_ph;
            d.start_ph_inc = cfg_start_ph_inc;
            d.dph_inc      = cfg_dph_inc;
            d.nph_shift    = cfg_nph_shift;
            d.ch_offset    = cfg_ch_offset;
        end
        if (go || (hs && eol)) begin
            d.phase  = d.start_ph;
            d.inc    = d.start_ph_inc;
            d.sph    = d.start_ph - d.nph_shift;
            d.ncount = CNT_WIDTH'(1);
            d.symb   = NSYMB_WIDTH'(1);
            d.loc    = go || eop ? '0 : q.loc + 1'b1;
        end else if (hs && eos) begin
            d.phase  = q.sph;
            d.sph    = q.sph - q.nph_shift;
            d.inc    = q.inc + q.dph_inc;
            d.ncount = CNT_WIDTH'(1);
            d.symb   = q.symb + 1'b1;
        end else if (hs) begin
            d.phase  = q.phase + q.inc;
            d.ncount = q.ncount + 1'b1;
        end
        if (go || hs) begin
            for (int k = 0; k < NCH; k++)
                d.tdata[k*PHASE_WIDTH +: PHASE_WIDTH] = (d.phase + d.ch_offset[k*PHASE_WIDTH +: PHASE_WIDTH]) ^ dith;
            d.tlast = d.ncount == d.nsig;
        end
    end
    // All state clears on async reset or sync clear; srst wins over start and handshakes
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) q <= '0;
        else q <= srst ? '0 : d;
    assign m_phase.tdata  = q.tdata;
    assign m_phase.tvalid = q.tvalid;
    assign m_phase.tlast  = q.tlast;
    assign busy           = q.state != IDLE;
    assign sync_ready     = q.sync_ready;
    assign cfg_err        = q.cfg_err;
    assign symb_n         = q.symb;
    assign loc_n          = q.loc;
endmodule

// File: tb/tb_tag_phase_seq.sv
// tb_tag_phase_seq: directed + randomized bench for tag_phase_seq against a closed-form phase model
module tb_tag_phase_seq;
    localparam int PW = 24, NCH = 2;
    logic clk = 0, reset_n = 1, srst = 0, start = 0, cfg_oneshot = 0;
    logic [23:0] cfg_nsig = '0;
    logic [15:0] cfg_nsymb = '0;
    logic [2:0] cfg_nloc = '0;
    logic [PW-1:0] cfg_start_ph = '0, cfg_start_ph_inc = '0, cfg_dph_inc = '0, cfg_nph_shift = '0;
    logic [NCH*PW-1:0] cfg_ch_offset = '0;
    logic busy, sync_ready, cfg_err;
    logic [15:0] symb_n;
    logic [2:0] loc_n;
    int vectors = 0, errors = 0;
    bit c_os;
    int c_nsig, c_nsymb, c_nloc;
    logic [PW-1:0] c_ph, c_inc, c_dph, c_shift;
    logic [PW-1:0] c_off [NCH];

    tag_phase_seq_if #(.PHASE_WIDTH(PW), .NCH(NCH)) m_phase ();

    tag_phase_seq dut (
        .clk(clk), .reset_n(reset_n), .srst(srst), .start(start), .cfg_oneshot(cfg_oneshot),
        .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb), .cfg_nloc(cfg_nloc),
        .cfg_start_ph(cfg_start_ph), .cfg_start_ph_inc(cfg_start_ph_inc),
        .cfg_dph_inc(cfg_dph_inc), .cfg_nph_shift(cfg_nph_shift), .cfg_ch_offset(cfg_ch_offset),
        .m_phase(m_phase), .busy(busy), .sync_ready(sync_ready), .cfg_err(cfg_err),
        .symb_n(symb_n), .loc_n(loc_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Symbol s (1-based) starts at start_ph-(s-1)*shift and steps by start_inc+(s-1)*dph
    function automatic logic [PW-1:0] ref_ph(input int s, input int n);
        logic [PW-1:0] sm, nm;
        sm = PW'(s - 1);
        nm = PW'(n - 1);
        return c_ph - sm * c_shift + nm * (c_inc + sm * c_dph);
    endfunction

    task automatic set_cfg(input bit os, input int ns, input int nsy, input int nl,
                           input logic [PW-1:0] ph, input logic [PW-1:0] inc, input logic [PW-1:0] dph,
                           input logic [PW-1:0] sh, input logic [PW-1:0] o0, input logic [PW-1:0] o1);
        c_os = os; c_nsig = ns; c_nsymb = nsy; c_nloc = nl;
        c_ph = ph; c_inc = inc; c_dph = dph; c_shift = sh; c_off[0] = o0; c_off[1] = o1;
        cfg_oneshot = os; cfg_nsig = 24'(ns); cfg_nsymb = 16'(nsy); cfg_nloc = 3'(nl);
        cfg_start_ph = ph; cfg_start_ph_inc = inc; cfg_dph_inc = dph; cfg_nph_shift = sh;
        cfg_ch_offset = {o1, o0};
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " tvalid"}, m_phase.tvalid, 0);
        chk({tag, " tdata"}, m_phase.tdata, 0);
        chk({tag, " tlast"}, m_phase.tlast, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " sync_ready"}, sync_ready, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " symb_n"}, symb_n, 0);
        chk({tag, " loc_n"}, loc_n, 0);
    endtask

    task automatic do_srst(input bit with_start);
        srst = 1; start = with_start; m_phase.tready = 1;
        @(negedge clk);
        srst = 0; start = 0; m_phase.tready = 0;
        chk_cleared("srst");
    endtask

    // mode 0: tready high, 1: toggling, 2: random tready plus ignored start pulses
    task automatic run(input int periods, input int mode, input int limit);
        int s = 1, n = 1, l = 0, p = 0, hcount = 0, cyc = 0;
        bit hs, exp_sync = 0;
        logic [PW-1:0] e;
        start = 1;
        @(negedge clk);
        start = 0;
        cfg_oneshot = 1'($urandom); cfg_nsig = 24'($urandom); cfg_nsymb = 16'($urandom);
        cfg_nloc = 3'($urandom); cfg_start_ph = PW'($urandom); cfg_start_ph_inc = PW'($urandom);
        cfg_dph_inc = PW'($urandom); cfg_nph_shift = PW'($urandom);
        cfg_ch_offset = {PW'($urandom), PW'($urandom)};
        while (p < periods && hcount < limit && cyc < 4000) begin
            chk("sync_ready", sync_ready, exp_sync);
            chk("tvalid", m_phase.tvalid, 1);
            chk("busy", busy, 1);
            chk("cfg_err", cfg_err, 0);
            for (int k = 0; k < NCH; k++) begin
                e = ref_ph(s, n) + c_off[k];
                chk($sformatf("ch%0d s%0d n%0d", k, s, n), m_phase.tdata[k*PW +: PW], e);
            end
            chk("tlast", m_phase.tlast, n == c_nsig);
            chk("symb_n", symb_n, s);
            chk("loc_n", loc_n, l);
            hs = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            m_phase.tready = hs;
            if (mode == 2) start = $urandom_range(0, 3) == 0;
            @(negedge clk);
            cyc++;
            exp_sync = 0;
            if (hs) begin
                hcount++;
                if (n < c_nsig) n++;
                else begin
                    n = 1;
                    if (s < c_nsymb) s++;
                    else begin
                        s = 1;
                        if (l < c_nloc - 1) l++;
                        else begin
                            l = 0; p++; exp_sync = 1;
                        end
                    end
                end
            end
        end
        start = 0;
        m_phase.tready = 0;
        chk("cycle bound", cyc < 4000, 1);
        if (hcount < limit) begin
            chk("sync_ready end", sync_ready, exp_sync);
            chk("tvalid end", m_phase.tvalid, !c_os);
            chk("busy end", busy, 1);
            if (c_os) begin
                @(negedge clk);
                chk("busy idle", busy, 0);
                chk("sync_ready drop", sync_ready, 0);
                chk("tvalid idle", m_phase.tvalid, 0);
            end
        end
    endtask

    task automatic bad_start(input int ns, input int nsy, input int nl);
        set_cfg(1, ns, nsy, nl, 24'h10, 24'h20, 24'h30, 24'h40, 0, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("cfg_err pulse", cfg_err, 1);
        chk("cfg_err tvalid", m_phase.tvalid, 0);
        chk("cfg_err busy", busy, 0);
        @(negedge clk);
        chk("cfg_err drop", cfg_err, 0);
        chk("cfg_err tvalid2", m_phase.tvalid, 0);
        chk("cfg_err busy2", busy, 0);
    endtask

    initial begin
        bit os;
        m_phase.tready = 0;
        #1 reset_n = 0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        reset_n = 1;
        @(negedge clk);
        set_cfg(1, 4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h0, 24'h0, 24'h0);
        run(1, 0, 1000);
        set_cfg(1, 4, 2, 1, 24'h0, 24'h100, 24'h100, 24'h0, 24'h0, 24'h0);
        run(1, 1, 1000);
        set_cfg(1, 3, 1, 1, 24'h2, 24'h5, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
        run(1, 0, 1000);
        bad_start(0, 2, 1);
        bad_start(3, 0, 1);
        bad_start(3, 2, 0);
        set_cfg(0, 2, 2, 3, 24'hFFFF00, 24'h80, 24'h40, 24'h10, 24'h123456, 24'hFEDCBA);
        run(2, 2, 100000);
        do_srst(0);
        set_cfg(1, 4, 3, 2, 24'h1000, 24'h11, 24'h22, 24'h33, 24'h5, 24'h6);
        run(1, 0, 5);
        do_srst(1);
        set_cfg(1, 4, 3, 2, 24'h1000, 24'h11, 24'h22, 24'h33, 24'h5, 24'h6);
        run(1, 0, 1000);
        for (int i = 0; i < 8; i++) begin
            os = 1'($urandom_range(0, 1));
            set_cfg(os, $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 4),
                    PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
            run(os ? 1 : 2, 2, 100000);
            if (!os) do_srst(0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/tag_phase_seq.md
TAG_PHASE_SEQ -- requirements
Module: tag_phase_seq

Interface
REQ-001 Parameter PHASE_WIDTH, default 24: width of every phase, increment and offset word.
REQ-002 Parameter CNT_WIDTH, default 24: width of the samples-per-symbol counter.
REQ-003 Parameter NSYMB_WIDTH, default 16: width of the symbols-per-location counter.
REQ-004 Parameter NLOC_WIDTH, default 3: width of the locations-per-sync counter.
REQ-005 Parameter NCH, default 2, range 1..8: number of phase output channels.
REQ-006 Parameter DITHER_BITS, default 4: number of LSBs dithered when dithering is compiled in.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 srst  in  1  synchronous clear, active-high.
REQ-010 start  in  1  single-cycle pulse that begins a sequence.
REQ-011 cfg_oneshot  in  1  1 = stop after one sync period; 0 = repeat.
REQ-012 cfg_nsig  in  CNT_WIDTH  samples per symbol.
REQ-013 cfg_nsymb  in  NSYMB_WIDTH  symbols per location.
REQ-014 cfg_nloc  in  NLOC_WIDTH  locations per sync period.
REQ-015 cfg_start_ph, cfg_start_ph_inc, cfg_dph_inc, cfg_nph_shift  in  PHASE_WIDTH each  start phase, first-symbol increment, per-symbol increment step, per-symbol start-phase shift.
REQ-016 cfg_ch_offset  in  NCH*PHASE_WIDTH  per-channel phase offset; channel k occupies bits [k*PHASE_WIDTH +: PHASE_WIDTH].
REQ-017 m_phase_tdata  out  NCH*PHASE_WIDTH  phase per channel, same packing as cfg_ch_offset.
REQ-018 m_phase_tvalid / m_phase_tready / m_phase_tlast  out/in/out  1 each  AXI-Stream handshake; tlast marks the last sample of a symbol.
REQ-019 busy, sync_ready, cfg_err  out  1 each  sequence running; one-cycle pulse at sync-period end; rejected start.
REQ-020 symb_n  out  NSYMB_WIDTH; loc_n  out  NLOC_WIDTH  current symbol and location indices.

Function
REQ-021 States SHALL be IDLE, RUN and DONE; m_phase_tvalid SHALL be 1 only in RUN.
REQ-022 In IDLE, start with cfg_nsig, cfg_nsymb and cfg_nloc all nonzero SHALL latch every cfg_* input and enter RUN; the first valid sample SHALL appear on the next cycle.
REQ-023 In IDLE, start with any of those three fields zero SHALL leave the block in IDLE and pulse cfg_err for one cycle.
REQ-024 start in RUN or DONE SHALL be ignored; cfg_* inputs SHALL be sampled only at an accepted start.
REQ-025 State SHALL advance only on tvalid&&tready; with tready low, tdata, tlast and all counters SHALL hold.
REQ-026 On entry to RUN: phase = start_ph; ncount = 1; symb_n = 1; loc_n = 0; inc = start_ph_inc; sph = start_ph − nph_shift.
REQ-027 On a handshake with ncount < nsig: phase += inc; ncount += 1.
REQ-028 On a handshake with ncount == nsig and symb_n < nsymb: ncount = 1; phase = sph; sph −= nph_shift; inc += dph_inc; symb_n += 1.
REQ-029 On a handshake with ncount == nsig and symb_n == nsymb: reload the REQ-026 values and set loc_n += 1.
REQ-030 When the REQ-029 handshake occurs with loc_n == nloc−1: sync_ready SHALL pulse, loc_n SHALL become 0, and the FSM SHALL go to DONE if cfg_oneshot=1, otherwise stay in RUN.
REQ-031 DONE SHALL last one cycle and then return to IDLE.
REQ-032 m_phase_tlast SHALL be 1 exactly when ncount == nsig.
REQ-033 Channel k tdata SHALL be (phase + ch_offset[k]) mod 2^PHASE_WIDTH.
REQ-034 All phase arithmetic SHALL wrap modulo 2^PHASE_WIDTH, with no saturation.
REQ-035 m_phase_tdata, m_phase_tvalid and m_phase_tlast SHALL be registered outputs.
REQ-036 busy SHALL be 1 in RUN and DONE.

Reset
REQ-037 reset_n low SHALL asynchronously force IDLE and clear every output and counter to 0; phase and all latched configuration SHALL also clear to 0.
REQ-038 srst high SHALL apply the same values synchronously and SHALL override start and any handshake in the same cycle, including mid-RUN.

Configuration
REQ-039 Macro TAG_PHASE_SEQ_DITHER_EN compiled in: a 16-bit maximal LFSR (seed 16'hACE1, advanced on each handshake) SHALL XOR its low DITHER_BITS into the low bits of each channel's output word. The accumulator SHALL be unaffected.
REQ-040 TAG_PHASE_SEQ_DITHER_EN compiled out: no LFSR SHALL exist, and outputs SHALL follow REQ-033 exactly.

Verification
REQ-041 nsig=4, nsymb=2, nloc=1, start_ph=0, start_ph_inc=0x100, dph_inc=0x100, nph_shift=0, oneshot=1, tready=1 -> ch0 = 0,0x100,0x200,0x300,0,0x200,0x400,0x600; tlast on samples 4 and 8; sync_ready at sample 8; IDLE two cycles later.
REQ-042 Same setup with tready toggling every cycle -> identical sample sequence, and tdata held while tready is low.
REQ-043 ch_offset[1]=0xFFFFFF, start_ph=0x000002 -> ch1 first sample = 0x000001 (wrap).
REQ-044 start with nsig=0 -> cfg_err pulses for one cycle, tvalid stays 0, busy stays 0.
REQ-045 oneshot=0, nloc=3 -> sync_ready pulses every 3 location periods; loc_n sequence 0,1,2,0.
REQ-046 srst asserted mid-symbol, then start -> sequence restarts from the REQ-026 values.
